// File: rtl/reset_seq_pkg.sv
// Shared types and defaults for the AIB reset sequencer.
// State encoding, default delays and the state-to-reset-output mapping.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PHY_WAIT  = 3'd1,
    ST_WAIT_LINK = 3'd2,
    ST_ADP_WAIT  = 3'd3,
    ST_USR_WAIT  = 3'd4,
    ST_RUN       = 3'd5,
    ST_ERROR     = 3'd6
  } seq_state_e;

  localparam int DEF_PHY_DLY  = 16;
  localparam int DEF_ADP_DLY  = 8;
  localparam int DEF_USR_DLY  = 8;
  localparam int DEF_LINK_TMO = 1024;
  localparam int DEF_CNT_W    = 12;

  // Returns {phy_rst_n, adapter_rst_n, user_rst, user_rst_n, seq_done, link_err}.
  function automatic logic [5:0] seq_outputs(input seq_state_e s);
    logic [5:0] v;
    v = 6'b001000;
    case (s)
      ST_WAIT_LINK,
      ST_ADP_WAIT:  v = 6'b101000;
      ST_USR_WAIT:  v = 6'b111000;
      ST_RUN:       v = 6'b110110;
      ST_ERROR:     v = 6'b001001;
      default:      v = 6'b001000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/reset_sequencer.sv
// Releases PHY, adapter and user resets in order once the AIB link is up,
// re-asserting adapter/user resets on link loss and flagging a link timeout.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int PHY_DLY  = DEF_PHY_DLY,
  parameter int ADP_DLY  = DEF_ADP_DLY,
  parameter int USR_DLY  = DEF_USR_DLY,
  parameter int LINK_TMO = DEF_LINK_TMO,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ms_tx_transfer_en,
  input  logic       i_sl_tx_transfer_en,
  input  logic       i_sw_reset_req,
  output logic       o_phy_rst_n,
  output logic       o_adapter_rst_n,
  output logic       o_user_rst,
  output logic       o_user_rst_n,
  output logic       o_seq_done,
  output logic       o_link_err,
  output logic [2:0] o_state
);

  localparam logic [CNT_W-1:0] PHY_LAST = CNT_W'(PHY_DLY - 1);
  localparam logic [CNT_W-1:0] ADP_LAST = CNT_W'(ADP_DLY - 1);
  localparam logic [CNT_W-1:0] USR_LAST = CNT_W'(USR_DLY - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LINK_TMO - 1);

  logic             w_ms_sync;
  logic             w_sl_sync;
  logic             w_link_up;
  seq_state_e       w_next;
  seq_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [5:0]       r_outs;

  sync_2ff u_sync_ms (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_ms_tx_transfer_en),
    .o_q     (w_ms_sync)
  );

  sync_2ff u_sync_sl (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_sl_tx_transfer_en),
    .o_q     (w_sl_sync)
  );

  assign w_link_up = w_ms_sync & w_sl_sync;

  // Priority: software reset, then link drop, then counter expiry.
  function automatic seq_state_e next_state(input seq_state_e s, input logic [CNT_W-1:0] cnt,
                                            input logic link_up, input logic sw_req);
    seq_state_e n;
    n = s;
    if (sw_req) begin
      n = ST_IDLE;
    end else begin
      case (s)
        ST_IDLE:      n = ST_PHY_WAIT;
        ST_PHY_WAIT:  if (cnt == PHY_LAST) n = ST_WAIT_LINK;
        ST_WAIT_LINK: if (link_up) n = ST_ADP_WAIT;
                      else if (cnt == TMO_LAST) n = ST_ERROR;
        ST_ADP_WAIT:  if (!link_up) n = ST_WAIT_LINK;
                      else if (cnt == ADP_LAST) n = ST_USR_WAIT;
        ST_USR_WAIT:  if (!link_up) n = ST_WAIT_LINK;
                      else if (cnt == USR_LAST) n = ST_RUN;
        ST_RUN:       if (!link_up) n = ST_WAIT_LINK;
        ST_ERROR:     n = ST_ERROR;
        default:      n = ST_IDLE;
      endcase
    end
    return n;
  endfunction

  assign w_next = next_state(r_state, r_cnt, w_link_up, i_sw_reset_req);

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_outs  <= 6'b001000;
    end else begin
      r_state <= w_next;
      r_outs  <= seq_outputs(w_next);
      if (w_next != r_state || r_state == ST_IDLE)
        r_cnt <= '0;
      else if (r_state != ST_RUN && r_state != ST_ERROR)
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign {o_phy_rst_n, o_adapter_rst_n, o_user_rst, o_user_rst_n, o_seq_done, o_link_err} = r_outs;
  assign o_state = r_state;

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter PHY_DLY, default 16, cycles from sequencer start to phy_rst_n release.
REQ-002 Parameter ADP_DLY, default 8, cycles from link-up to adapter_rst_n release.
REQ-003 Parameter USR_DLY, default 8, cycles from adapter release to user reset release.
REQ-004 Parameter LINK_TMO, default 1024, cycles allowed in WAIT_LINK before error.
REQ-005 Parameter CNT_W, default 12, counter width, SHALL satisfy 2^CNT_W > max(PHY_DLY, ADP_DLY, USR_DLY, LINK_TMO).
REQ-006 clk  input  1  single clock; all logic on posedge.
REQ-007 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 ms_tx_transfer_en  input  1  leader-side link ready, asynchronous to clk.
REQ-009 sl_tx_transfer_en  input  1  follower-side link ready, asynchronous to clk.
REQ-010 sw_reset_req  input  1  synchronous one-cycle request to restart the sequence.
REQ-011 phy_rst_n  output  1  AIB PHY reset, active-low.
REQ-012 adapter_rst_n  output  1  adapter reset, active-low.
REQ-013 user_rst  output  1  user logic reset, active-high.
REQ-014 user_rst_n  output  1  user logic reset, active-low, always the inverse of user_rst.
REQ-015 seq_done  output  1  high only in RUN.
REQ-016 link_err  output  1  high only in ERROR.
REQ-017 state  output  3  current FSM state encoding.

Function
REQ-018 Both transfer-enable inputs SHALL pass through a 2-flop synchronizer; link_up = AND of the synchronized values.
REQ-019 FSM states: IDLE, PHY_WAIT, WAIT_LINK, ADP_WAIT, USR_WAIT, RUN, ERROR.
REQ-020 IDLE -> PHY_WAIT unconditionally on the first clock after reset release; counter cleared.
REQ-021 PHY_WAIT: count up; at count == PHY_DLY-1 -> WAIT_LINK, phy_rst_n goes 1 on the same edge.
REQ-022 WAIT_LINK: link_up high -> ADP_WAIT; count reaching LINK_TMO-1 with link_up low -> ERROR; link_up has priority on the same cycle.
REQ-023 ADP_WAIT: at count == ADP_DLY-1 -> USR_WAIT, adapter_rst_n goes 1 on the same edge.
REQ-024 USR_WAIT: at count == USR_DLY-1 -> RUN, user_rst goes 0 on the same edge.
REQ-025 Counter SHALL clear on every state change; no wrap-around is possible within any state.
REQ-026 link_up low in ADP_WAIT, USR_WAIT or RUN -> WAIT_LINK next cycle; adapter_rst_n=0 and user_rst=1 on that edge; phy_rst_n stays 1.
REQ-027 ERROR SHALL hold until sw_reset_req; phy_rst_n=0, adapter_rst_n=0, user_rst=1.
REQ-028 sw_reset_req in any state -> IDLE next cycle, with all resets asserted on that edge.
REQ-029 Priority on simultaneous events: sw_reset_req > link drop > counter expiry.
REQ-030 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-031 Release order SHALL always be phy -> adapter -> user; assertion order on a link drop is adapter and user together.

Reset
REQ-032 rst_n low SHALL immediately force: state=IDLE, counter=0, synchronizer flops=0, phy_rst_n=0, adapter_rst_n=0, user_rst=1, user_rst_n=0, seq_done=0, link_err=0.
REQ-033 Mid-sequence assertion of rst_n SHALL abort the sequence and apply REQ-032 without waiting for clk.

Structure
REQ-034 State encoding enum and default delay constants SHALL live in a shared package, reset_seq_pkg.
REQ-035 The 2-flop synchronizer SHALL be a separate sub-module, sync_2ff, instantiated once per input.

Verification
REQ-036 Nominal: release rst_n, both enables high from cycle 0 -> phy_rst_n rises at cycle 16, adapter_rst_n rises at cycle 16+2+8, user_rst falls 8 cycles later, seq_done=1.
REQ-037 Timeout: sl_tx_transfer_en held low -> link_err=1 exactly 1024 cycles after WAIT_LINK entry; a sw_reset_req pulse then returns the FSM to IDLE and asserts all resets.
REQ-038 Link drop in RUN: deassert ms_tx_transfer_en -> adapter_rst_n=0 and user_rst=1 three cycles later, phy_rst_n stays 1; restoring the enable repeats the ADP_WAIT/USR_WAIT timing.
REQ-039 Simultaneous: sw_reset_req on the same cycle as USR_WAIT expiry -> next state IDLE, user_rst stays 1.
REQ-040 Async reset: assert rst_n between clock edges while in RUN -> all outputs at their reset values before the next posedge.
REQ-041 Ordering check: an assertion SHALL verify that adapter_rst_n never rises while phy_rst_n=0 and that user_rst never falls while adapter_rst_n=0, across all scenarios.
